// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master arbiter for a single synchronous memory port
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_rstrb_i,
  input  logic [3:0]  m0_wmask_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_busy_o,
  output logic        m0_done_o,
  output logic [31:0] m0_rdata_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_rstrb_i,
  input  logic [3:0]  m1_wmask_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_busy_o,
  output logic        m1_done_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_rstrb_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  done_q, done_d;
  logic [31:0] addr_q  [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_q [2];
  logic [31:0] wdata_d [2];
  logic [3:0]  wmask_q [2];
  logic [3:0]  wmask_d [2];
  logic [1:0]  wr_q, wr_d;
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        mem_rstrb_q, mem_rstrb_d;

  logic [31:0] in_addr  [2];
  logic [31:0] in_wdata [2];
  logic [3:0]  in_wmask [2];
  logic [1:0]  in_rstrb;
  logic [1:0]  req;
  logic [1:0]  cand;
  logic        sel;
  logic        oth;

  assign in_addr[0]  = m0_addr_i;
  assign in_addr[1]  = m1_addr_i;
  assign in_wdata[0] = m0_wdata_i;
  assign in_wdata[1] = m1_wdata_i;
  assign in_wmask[0] = m0_wmask_i;
  assign in_wmask[1] = m1_wmask_i;
  assign in_rstrb    = {m1_rstrb_i, m0_rstrb_i};

  // A master may only start a request while its slot is empty; strobes while busy are dropped
  assign req[0] = ~pend_q[0] & (in_rstrb[0] | (|in_wmask[0]));
  assign req[1] = ~pend_q[1] & (in_rstrb[1] | (|in_wmask[1]));

  // Grant choice among candidate slots; round-robin ties go to the master not granted last
  function automatic logic pick(input logic [1:0] c, input logic last);
    if (FIXED_PRIO) return c[0] ? 1'b0 : 1'b1;
    if (c == 2'b11) return ~last;
    return c[0] ? 1'b0 : 1'b1;
  endfunction

  // Next-state logic: slot capture, arbitration, memory port drive and completion
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    pend_d      = pend_q;
    done_d      = 2'b00;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    mem_rstrb_d = mem_rstrb_q;
    cand        = 2'b00;
    sel         = 1'b0;
    oth         = ~gnt_q;
    for (int n = 0; n < 2; n++) begin
      addr_d[n]  = addr_q[n];
      wdata_d[n] = wdata_q[n];
      wmask_d[n] = wmask_q[n];
      rdata_d[n] = rdata_q[n];
      if (req[n]) begin
        pend_d[n]  = 1'b1;
        addr_d[n]  = in_addr[n];
        wdata_d[n] = in_wdata[n];
        wmask_d[n] = in_wmask[n];
        wr_d[n]    = |in_wmask[n];
      end
    end

    case (state_q)
      IDLE: begin
        // Requests arriving this cycle are eligible so an idle port issues on the next cycle
        cand = pend_q | req;
        if (|cand) begin
          sel         = pick(cand, last_q);
          state_d     = ISSUE;
          gnt_d       = sel;
          last_d      = sel;
          mem_addr_d  = addr_d[sel];
          mem_wdata_d = wdata_d[sel];
          mem_rstrb_d = ~wr_d[sel];
          mem_wmask_d = wr_d[sel] ? wmask_d[sel] : 4'b0000;
        end else begin
          mem_addr_d  = 32'h0;
          mem_wdata_d = 32'h0;
          mem_rstrb_d = 1'b0;
          mem_wmask_d = 4'b0000;
        end
      end
      ISSUE: begin
        state_d     = CAPT;
        mem_rstrb_d = 1'b0;
        mem_wmask_d = 4'b0000;
      end
      CAPT: begin
        if (!wr_q[gnt_q]) rdata_d[gnt_q] = mem_rdata_i;
        pend_d[gnt_q] = 1'b0;
        done_d[gnt_q] = 1'b1;
        // Only a slot already pending before this cycle competes here
        if (pend_q[oth]) begin
          state_d     = ISSUE;
          gnt_d       = oth;
          last_d      = oth;
          mem_addr_d  = addr_q[oth];
          mem_wdata_d = wdata_q[oth];
          mem_rstrb_d = ~wr_q[oth];
          mem_wmask_d = wr_q[oth] ? wmask_q[oth] : 4'b0000;
        end else begin
          state_d     = IDLE;
          mem_addr_d  = 32'h0;
          mem_wdata_d = 32'h0;
          mem_rstrb_d = 1'b0;
          mem_wmask_d = 4'b0000;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_addr_d  = 32'h0;
        mem_wdata_d = 32'h0;
        mem_rstrb_d = 1'b0;
        mem_wmask_d = 4'b0000;
      end
    endcase
  end

  // State and registered outputs; last starts at 1 so master 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      pend_q      <= 2'b00;
      done_q      <= 2'b00;
      wr_q        <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'b0000;
      mem_rstrb_q <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        addr_q[n]  <= 32'h0;
        wdata_q[n] <= 32'h0;
        wmask_q[n] <= 4'b0000;
        rdata_q[n] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      mem_rstrb_q <= mem_rstrb_d;
      for (int n = 0; n < 2; n++) begin
        addr_q[n]  <= addr_d[n];
        wdata_q[n] <= wdata_d[n];
        wmask_q[n] <= wmask_d[n];
        rdata_q[n] <= rdata_d[n];
      end
    end
  end

  assign m0_busy_o   = pend_q[0];
  assign m1_busy_o   = pend_q[1];
  assign m0_done_o   = done_q[0];
  assign m1_done_o   = done_q[1];
  assign m0_rdata_o  = rdata_q[0];
  assign m1_rdata_o  = rdata_q[1];
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;
  assign mem_rstrb_o = mem_rstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_rstrb, m1_rstrb;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_busy, m0_done, m1_busy, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  logic [31:0] f_m0_addr, f_m0_wdata, f_m1_addr, f_m1_wdata;
  logic        f_m0_rstrb, f_m1_rstrb;
  logic [3:0]  f_m0_wmask, f_m1_wmask;
  logic        f_m0_busy, f_m0_done, f_m1_busy, f_m1_done;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic        f_mem_rstrb;
  logic [3:0]  f_mem_wmask;

  int n_cmp = 0;
  int n_fail = 0;

  mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_addr_i(m0_addr), .m0_rstrb_i(m0_rstrb), .m0_wmask_i(m0_wmask), .m0_wdata_i(m0_wdata),
    .m0_busy_o(m0_busy), .m0_done_o(m0_done), .m0_rdata_o(m0_rdata),
    .m1_addr_i(m1_addr), .m1_rstrb_i(m1_rstrb), .m1_wmask_i(m1_wmask), .m1_wdata_i(m1_wdata),
    .m1_busy_o(m1_busy), .m1_done_o(m1_done), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_rstrb_o(mem_rstrb), .mem_wmask_o(mem_wmask),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_addr_i(f_m0_addr), .m0_rstrb_i(f_m0_rstrb), .m0_wmask_i(f_m0_wmask), .m0_wdata_i(f_m0_wdata),
    .m0_busy_o(f_m0_busy), .m0_done_o(f_m0_done), .m0_rdata_o(f_m0_rdata),
    .m1_addr_i(f_m1_addr), .m1_rstrb_i(f_m1_rstrb), .m1_wmask_i(f_m1_wmask), .m1_wdata_i(f_m1_wdata),
    .m1_busy_o(f_m1_busy), .m1_done_o(f_m1_done), .m1_rdata_o(f_m1_rdata),
    .mem_addr_o(f_mem_addr), .mem_rstrb_o(f_mem_rstrb), .mem_wmask_o(f_mem_wmask),
    .mem_wdata_o(f_mem_wdata), .mem_rdata_i(f_mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // Memory: read data appears the cycle after the strobe, garbage otherwise
  always @(posedge clk) mem_rdata <= mem_rstrb ? memval(mem_addr) : $urandom;
  always @(posedge clk) f_mem_rdata <= f_mem_rstrb ? memval(f_mem_addr) : $urandom;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  task automatic idle_inputs;
    m0_addr = 0; m0_rstrb = 0; m0_wmask = 0; m0_wdata = 0;
    m1_addr = 0; m1_rstrb = 0; m1_wmask = 0; m1_wdata = 0;
    f_m0_addr = 0; f_m0_rstrb = 0; f_m0_wmask = 0; f_m0_wdata = 0;
    f_m1_addr = 0; f_m1_rstrb = 0; f_m1_wmask = 0; f_m1_wdata = 0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({m0_busy, m1_busy, m0_done, m1_done, mem_rstrb} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {m0_busy, m1_busy, m0_done, m1_done, mem_rstrb}); end
    n_cmp++; if ({mem_addr, mem_wdata, mem_wmask} !== 68'h0) begin n_fail++; $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata, mem_wmask}); end
    n_cmp++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
    rst_n = 1'b1;
    next_cycle();
    n_cmp++; if ({m0_busy, m1_busy, mem_rstrb, mem_wmask} !== 7'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", {m0_busy, m1_busy, mem_rstrb, mem_wmask}); end
  endtask

  task automatic test_single_read;
    do_reset();
    m0_addr = 32'h100; m0_rstrb = 1'b1;
    next_cycle(); idle_inputs();
    n_cmp++; if ({mem_rstrb, mem_wmask, mem_addr} !== {1'b1, 4'b0, 32'h100}) begin n_fail++; $display("FAIL rd_issue: got %h want %h", {mem_rstrb, mem_wmask, mem_addr}, {1'b1, 4'b0, 32'h100}); end
    n_cmp++; if (m0_busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy1: got %b want 1", m0_busy); end
    next_cycle();
    n_cmp++; if ({m0_busy, m0_done, mem_rstrb} !== 3'b100) begin n_fail++; $display("FAIL rd_capt: got %b want 100", {m0_busy, m0_done, mem_rstrb}); end
    next_cycle();
    n_cmp++; if ({m0_done, m0_busy} !== 2'b10) begin n_fail++; $display("FAIL rd_done: got %b want 10", {m0_done, m0_busy}); end
    n_cmp++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", m0_rdata); end
    next_cycle();
    n_cmp++; if ({m0_done, m0_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd_hold: got %h want %h", {m0_done, m0_rdata}, {1'b0, 32'hDEADBEEF}); end
  endtask

  task automatic test_single_write;
    logic [31:0] prev;
    prev = m1_rdata;
    m1_addr = 32'h204; m1_wmask = 4'b0011; m1_wdata = 32'h0000ABCD;
    next_cycle(); idle_inputs();
    n_cmp++; if ({mem_rstrb, mem_wmask, mem_addr, mem_wdata} !== {1'b0, 4'b0011, 32'h204, 32'h0000ABCD}) begin n_fail++; $display("FAIL wr_issue: got %h want %h", {mem_rstrb, mem_wmask, mem_addr, mem_wdata}, {1'b0, 4'b0011, 32'h204, 32'h0000ABCD}); end
    next_cycle();
    next_cycle();
    n_cmp++; if ({m1_done, m0_done, m1_busy} !== 3'b100) begin n_fail++; $display("FAIL wr_done: got %b want 100", {m1_done, m0_done, m1_busy}); end
    n_cmp++; if (m1_rdata !== prev) begin n_fail++; $display("FAIL wr_rdata: got %h want %h", m1_rdata, prev); end
  endtask

  task automatic test_rr_tie;
    do_reset();
    m0_addr = 32'h40; m0_rstrb = 1'b1; m1_addr = 32'h80; m1_rstrb = 1'b1;
    next_cycle(); idle_inputs();
    n_cmp++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL rr_first: got %h want 40", mem_addr); end
    next_cycle(); next_cycle();
    n_cmp++; if ({mem_rstrb, mem_addr, m0_done} !== {1'b1, 32'h80, 1'b1}) begin n_fail++; $display("FAIL rr_second: got %h want %h", {mem_rstrb, mem_addr, m0_done}, {1'b1, 32'h80, 1'b1}); end
    next_cycle(); next_cycle();
    n_cmp++; if ({m1_done, m0_done, m1_rdata} !== {2'b10, memval(32'h80)}) begin n_fail++; $display("FAIL rr_m1done: got %h want %h", {m1_done, m0_done, m1_rdata}, {2'b10, memval(32'h80)}); end
    m0_addr = 32'h44; m0_rstrb = 1'b1;
    next_cycle(); idle_inputs();
    next_cycle(); next_cycle();
    n_cmp++; if (m0_done !== 1'b1) begin n_fail++; $display("FAIL rr_solo_done: got %b want 1", m0_done); end
    m0_addr = 32'h48; m0_rstrb = 1'b1; m1_addr = 32'h88; m1_rstrb = 1'b1;
    next_cycle(); idle_inputs();
    n_cmp++; if (mem_addr !== 32'h88) begin n_fail++; $display("FAIL rr_tie2_first: got %h want 88", mem_addr); end
    next_cycle(); next_cycle();
    n_cmp++; if (mem_addr !== 32'h48) begin n_fail++; $display("FAIL rr_tie2_second: got %h want 48", mem_addr); end
    next_cycle(); next_cycle();
  endtask

  task automatic test_fixed_prio;
    do_reset();
    f_m0_addr = 32'h40; f_m0_rstrb = 1'b1;
    next_cycle(); idle_inputs();
    n_cmp++; if (f_mem_addr !== 32'h40) begin n_fail++; $display("FAIL fp_solo: got %h want 40", f_mem_addr); end
    next_cycle(); next_cycle();
    f_m0_addr = 32'h48; f_m0_rstrb = 1'b1; f_m1_addr = 32'h88; f_m1_rstrb = 1'b1;
    next_cycle(); idle_inputs();
    n_cmp++; if (f_mem_addr !== 32'h48) begin n_fail++; $display("FAIL fp_tie_first: got %h want 48", f_mem_addr); end
    n_cmp++; if (f_m1_busy !== 1'b1) begin n_fail++; $display("FAIL fp_m1_wait: got %b want 1", f_m1_busy); end
    next_cycle(); next_cycle();
    n_cmp++; if (f_mem_addr !== 32'h88) begin n_fail++; $display("FAIL fp_tie_second: got %h want 88", f_mem_addr); end
    next_cycle(); next_cycle();
  endtask

  task automatic test_drop_precedence;
    int acc, rds, d0, d1;
    logic [35:0] wr_seen;
    acc = 0; rds = 0; d0 = 0; d1 = 0; wr_seen = '0;
    do_reset();
    m0_addr = 32'h10; m0_rstrb = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      next_cycle();
      idle_inputs();
      if (i <= 2) begin
        m0_addr = 32'h20; m0_wmask = 4'b1111; m0_wdata = 32'h7777;
      end
      if (i == 1) begin
        m1_addr = 32'h30; m1_rstrb = 1'b1; m1_wmask = 4'b1111; m1_wdata = 32'h5555;
      end
      if (mem_rstrb || mem_wmask != 0) acc++;
      if (mem_rstrb) rds++;
      if (mem_wmask != 0) wr_seen = {mem_addr, mem_wmask};
      if (m0_done) d0++;
      if (m1_done) d1++;
    end
    idle_inputs();
    n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL drop_accesses: got %0d want 2", acc); end
    n_cmp++; if (rds !== 1) begin n_fail++; $display("FAIL prec_rstrb: got %0d want 1", rds); end
    n_cmp++; if (wr_seen !== {32'h30, 4'b1111}) begin n_fail++; $display("FAIL prec_write: got %h want %h", wr_seen, {32'h30, 4'b1111}); end
    n_cmp++; if ({d0, d1} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL drop_dones: got %0d/%0d want 1/1", d0, d1); end
  endtask

  task automatic test_reset_mid;
    int dn, acc;
    dn = 0; acc = 0;
    do_reset();
    m0_addr = 32'h60; m0_rstrb = 1'b1;
    next_cycle(); idle_inputs();
    m1_addr = 32'h64; m1_rstrb = 1'b1;
    next_cycle(); idle_inputs();
    n_cmp++; if ({m1_busy, mem_addr} !== {1'b1, 32'h60}) begin n_fail++; $display("FAIL mid_pre: got %h want %h", {m1_busy, mem_addr}, {1'b1, 32'h60}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_addr, mem_wdata, mem_wmask, mem_rstrb} !== 69'h0) begin n_fail++; $display("FAIL mid_mem: got %h want 0", {mem_addr, mem_wdata, mem_wmask, mem_rstrb}); end
    n_cmp++; if ({m0_busy, m1_busy, m0_done, m1_done, m0_rdata, m1_rdata} !== 68'h0) begin n_fail++; $display("FAIL mid_master: got %h want 0", {m0_busy, m1_busy, m0_done, m1_done, m0_rdata, m1_rdata}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (m0_done || m1_done) dn++;
      if (mem_rstrb || mem_wmask != 0 || m0_busy || m1_busy) acc++;
    end
    n_cmp++; if (dn !== 0) begin n_fail++; $display("FAIL mid_done_after: got %0d want 0", dn); end
    n_cmp++; if (acc !== 0) begin n_fail++; $display("FAIL mid_activity_after: got %0d want 0", acc); end
  endtask

  // Reference model: transaction timeline of one shared port
  int          r_phase;
  logic        r_g, r_last;
  logic [1:0]  r_pend;
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_wmask [2];
  logic [1:0]  r_wr;
  logic [1:0]  e_busy, e_done;
  logic [31:0] e_rdata [2];
  logic [31:0] e_maddr, e_mwdata;
  logic [3:0]  e_mwmask;
  logic        e_mrstrb;

  task automatic model_issue(input logic x);
    r_phase = 1; r_g = x; r_last = x;
    e_maddr = r_addr[x]; e_mwdata = r_wdata[x];
    e_mrstrb = ~r_wr[x]; e_mwmask = r_wr[x] ? r_wmask[x] : 4'b0;
  endtask

  task automatic model_idle;
    r_phase = 0; e_maddr = 0; e_mwdata = 0; e_mrstrb = 0; e_mwmask = 0;
  endtask

  task automatic test_random;
    logic [1:0]  rq, old_pend, cand;
    logic        rs [2];
    logic [3:0]  wm [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    do_reset();
    r_last = 1'b1; r_g = 1'b0; r_pend = 0; r_wr = 0;
    e_busy = 0; e_done = 0; e_rdata[0] = 0; e_rdata[1] = 0;
    model_idle();
    for (int n = 0; n < 2; n++) begin r_addr[n] = 0; r_wdata[n] = 0; r_wmask[n] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) begin
        n_cmp++; if ({m1_busy, m0_busy} !== e_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, {m1_busy, m0_busy}, e_busy); end
        n_cmp++; if ({m1_done, m0_done} !== e_done) begin n_fail++; $display("FAIL rnd_done c%0d: got %b want %b", cyc, {m1_done, m0_done}, e_done); end
        n_cmp++; if (m0_rdata !== e_rdata[0]) begin n_fail++; $display("FAIL rnd_rdata0 c%0d: got %h want %h", cyc, m0_rdata, e_rdata[0]); end
        n_cmp++; if (m1_rdata !== e_rdata[1]) begin n_fail++; $display("FAIL rnd_rdata1 c%0d: got %h want %h", cyc, m1_rdata, e_rdata[1]); end
        n_cmp++; if (mem_addr !== e_maddr) begin n_fail++; $display("FAIL rnd_maddr c%0d: got %h want %h", cyc, mem_addr, e_maddr); end
        n_cmp++; if (mem_wdata !== e_mwdata) begin n_fail++; $display("FAIL rnd_mwdata c%0d: got %h want %h", cyc, mem_wdata, e_mwdata); end
        n_cmp++; if (mem_wmask !== e_mwmask) begin n_fail++; $display("FAIL rnd_mwmask c%0d: got %h want %h", cyc, mem_wmask, e_mwmask); end
        n_cmp++; if (mem_rstrb !== e_mrstrb) begin n_fail++; $display("FAIL rnd_mrstrb c%0d: got %b want %b", cyc, mem_rstrb, e_mrstrb); end
      end
      for (int n = 0; n < 2; n++) begin
        rs[n] = ($urandom_range(0, 2) == 0);
        wm[n] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
        ad[n] = $urandom & 32'hFFFF_FFFC;
        wd[n] = $urandom;
      end
      m0_rstrb = rs[0]; m0_wmask = wm[0]; m0_addr = ad[0]; m0_wdata = wd[0];
      m1_rstrb = rs[1]; m1_wmask = wm[1]; m1_addr = ad[1]; m1_wdata = wd[1];
      old_pend = r_pend;
      for (int n = 0; n < 2; n++) begin
        rq[n] = ~r_pend[n] & (rs[n] | (wm[n] != 0));
        if (rq[n]) begin
          r_pend[n] = 1'b1; r_addr[n] = ad[n]; r_wdata[n] = wd[n];
          r_wmask[n] = wm[n]; r_wr[n] = (wm[n] != 0);
        end
      end
      e_done = 0;
      if (r_phase == 2) begin
        if (!r_wr[r_g]) e_rdata[r_g] = memval(e_maddr);
        e_done[r_g] = 1'b1;
        r_pend[r_g] = 1'b0;
        if (old_pend[~r_g]) model_issue(~r_g);
        else model_idle();
      end else if (r_phase == 1) begin
        r_phase = 2; e_mrstrb = 0; e_mwmask = 0;
      end else begin
        cand = r_pend;
        if (cand == 2'b11) model_issue(~r_last);
        else if (cand == 2'b01) model_issue(1'b0);
        else if (cand == 2'b10) model_issue(1'b1);
      end
      e_busy = r_pend;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_single_write();
    test_rr_tie();
    test_fixed_prio();
    test_drop_precedence();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
